// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - in-order expected-store checker for a processor data-memory write port
//
// Purpose:
//   Holds a small queue of expected (address, data) stores loaded while IDLE.
//   After start, it watches the processor store port and matches stores
//   against the queue in order. The result is a sticky PASS or FAIL, with an
//   error code, a capture of the offending store and a RUN cycle counter.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   clear              synchronous return to IDLE with an empty queue
//   exp_valid/_ready   expected-entry handshake (exp_addr, exp_data)
//   start              begin checking (IDLE only)
//   memwrite, dataadr, writedata, pc   observed processor store
//   done, pass, fail, err_code         sticky verdict (err: 0 none, 1 mismatch, 2 timeout, 3 empty)
//   match_count        entries matched so far
//   fail_pc/addr/data  captured offending store (mismatch only)
//   cycle_count        RUN-state cycles elapsed, saturating

module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1000,
    parameter int STRICT  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     exp_valid,
    input  logic [WIDTH-1:0]         exp_addr,
    input  logic [WIDTH-1:0]         exp_data,
    output logic                     exp_ready,
    input  logic                     start,
    input  logic                     memwrite,
    input  logic [WIDTH-1:0]         dataadr,
    input  logic [WIDTH-1:0]         writedata,
    input  logic [WIDTH-1:0]         pc,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH):0]   match_count,
    output logic [WIDTH-1:0]         fail_pc,
    output logic [WIDTH-1:0]         fail_addr,
    output logic [WIDTH-1:0]         fail_data,
    output logic [31:0]              cycle_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_EMPTY    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        err_q, err_d;
    logic [CW-1:0]     match_q, match_d;
    logic [WIDTH-1:0]  fpc_q, fpc_d;
    logic [WIDTH-1:0]  faddr_q, faddr_d;
    logic [WIDTH-1:0]  fdata_q, fdata_d;
    logic [31:0]       cyc_q, cyc_d;

    logic [WIDTH-1:0]  addr_mem [DEPTH];
    logic [WIDTH-1:0]  data_mem [DEPTH];

    logic              wr_en;
    logic              accept;
    logic              addr_hit;
    logic              data_hit;

    assign exp_ready = (state_q == S_IDLE) && (count_q < DEPTH_C);
    assign accept    = exp_valid && exp_ready;

    // Queue storage carries no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_mem[wr_ptr_q] <= exp_addr;
            data_mem[wr_ptr_q] <= exp_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        match_d  = match_q;
        fpc_d    = fpc_q;
        faddr_d  = faddr_q;
        fdata_d  = fdata_q;
        cyc_d    = cyc_q;
        wr_en    = 1'b0;
        addr_hit = memwrite && (dataadr == addr_mem[rd_ptr_q]);
        data_hit = (writedata == data_mem[rd_ptr_q]);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                // count_d already includes an entry accepted on the start edge
                if (start) begin
                    if (count_d == '0) begin
                        state_d = S_FAIL;
                        done_d  = 1'b1;
                        fail_d  = 1'b1;
                        err_d   = ERR_EMPTY;
                    end else begin
                        state_d  = S_RUN;
                        rd_ptr_d = '0;
                        match_d  = '0;
                        cyc_d    = '0;
                    end
                end
            end

            S_RUN: begin
                if (cyc_q != '1) begin
                    cyc_d = cyc_q + 1'b1;
                end
                if (addr_hit && data_hit) begin
                    match_d  = match_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (match_d == count_q) begin
                        state_d = S_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end else if (addr_hit || (memwrite && (STRICT != 0))) begin
                    state_d = S_FAIL;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    err_d   = ERR_MISMATCH;
                    fpc_d   = pc;
                    faddr_d = dataadr;
                    fdata_d = writedata;
                end
                // Only fires if no store above already decided the outcome,
                // so a completing match on the last cycle still passes.
                if ((state_d == S_RUN) && (cyc_q == TO_LAST)) begin
                    state_d = S_FAIL;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end
            end

            default: begin
                // PASS and FAIL are sticky until clear or reset
            end
        endcase

        if (clear) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
            err_d    = ERR_NONE;
            match_d  = '0;
            fpc_d    = '0;
            faddr_d  = '0;
            fdata_d  = '0;
            cyc_d    = '0;
            wr_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= ERR_NONE;
            match_q  <= '0;
            fpc_q    <= '0;
            faddr_q  <= '0;
            fdata_q  <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            match_q  <= match_d;
            fpc_q    <= fpc_d;
            faddr_q  <= faddr_d;
            fdata_q  <= fdata_d;
            cyc_q    <= cyc_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign err_code    = err_q;
    assign match_count = match_q;
    assign fail_pc     = fpc_q;
    assign fail_addr   = faddr_q;
    assign fail_data   = fdata_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - testbench for mem_write_checker (STRICT=0 and STRICT=1 side by side)

module tb_mem_write_checker;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        start = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] pc = '0;

    logic        rdy_w  [2];
    logic        done_w [2];
    logic        pass_w [2];
    logic        fail_w [2];
    logic [1:0]  err_w  [2];
    logic [2:0]  mc_w   [2];
    logic [31:0] fpc_w  [2];
    logic [31:0] fa_w   [2];
    logic [31:0] fd_w   [2];
    logic [31:0] cc_w   [2];

    always #5 clk = ~clk;

    mem_write_checker #(.WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(0)) dut_lax (
        .clk(clk), .reset(reset), .clear(clear),
        .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(rdy_w[0]),
        .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .pc(pc),
        .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .err_code(err_w[0]),
        .match_count(mc_w[0]), .fail_pc(fpc_w[0]), .fail_addr(fa_w[0]), .fail_data(fd_w[0]),
        .cycle_count(cc_w[0])
    );

    mem_write_checker #(.WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(1)) dut_strict (
        .clk(clk), .reset(reset), .clear(clear),
        .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(rdy_w[1]),
        .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .pc(pc),
        .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .err_code(err_w[1]),
        .match_count(mc_w[1]), .fail_pc(fpc_w[1]), .fail_addr(fa_w[1]), .fail_data(fd_w[1]),
        .cycle_count(cc_w[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: list of loaded entries plus, per checker, an outcome
    // (0 idle, 1 checking, 2 passed, 3 failed) and the result registers.
    logic [31:0] la [$];
    logic [31:0] ld [$];
    int          mst   [2];
    int          mmatch[2];
    int          mcyc  [2];
    int          merr  [2];
    logic [31:0] mfpc  [2];
    logic [31:0] mfa   [2];
    logic [31:0] mfd   [2];

    logic [31:0] en_a [8];
    logic [31:0] en_d [8];
    int          n_en;
    bit          merge;
    bit          s_mw [20];
    logic [31:0] s_a  [20];
    logic [31:0] s_d  [20];
    logic [31:0] s_pc [20];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        la.delete();
        ld.delete();
        for (int v = 0; v < 2; v++) begin
            mst[v] = 0; mmatch[v] = 0; mcyc[v] = 0; merr[v] = 0;
            mfpc[v] = '0; mfa[v] = '0; mfd[v] = '0;
        end
    endtask

    task automatic model_edge(input bit ev, input logic [31:0] ea, input logic [31:0] ed,
                              input bit st, input bit mw, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] p);
        if (mst[0] == 0) begin
            if (ev && la.size() < DEPTH) begin
                la.push_back(ea);
                ld.push_back(ed);
            end
            if (st) begin
                for (int v = 0; v < 2; v++) begin
                    if (la.size() == 0) begin
                        mst[v] = 3; merr[v] = 3;
                    end else begin
                        mst[v] = 1; mcyc[v] = 0; mmatch[v] = 0;
                    end
                end
            end
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (mst[v] == 1) begin
                    mcyc[v]++;
                    if (mw && a == la[mmatch[v]] && d == ld[mmatch[v]]) begin
                        mmatch[v]++;
                        if (mmatch[v] == la.size()) mst[v] = 2;
                    end else if (mw && (a == la[mmatch[v]] || v == 1)) begin
                        mst[v] = 3; merr[v] = 1;
                        mfpc[v] = p; mfa[v] = a; mfd[v] = d;
                    end
                    if (mst[v] == 1 && mcyc[v] == TIMEOUT) begin
                        mst[v] = 3; merr[v] = 2;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("%s.done.s%0d", tag, v), 32'(done_w[v]), 32'(mst[v] >= 2));
            chk($sformatf("%s.pass.s%0d", tag, v), 32'(pass_w[v]), 32'(mst[v] == 2));
            chk($sformatf("%s.fail.s%0d", tag, v), 32'(fail_w[v]), 32'(mst[v] == 3));
            chk($sformatf("%s.err.s%0d", tag, v), 32'(err_w[v]), 32'(merr[v]));
            chk($sformatf("%s.match.s%0d", tag, v), 32'(mc_w[v]), 32'(mmatch[v]));
            chk($sformatf("%s.cycles.s%0d", tag, v), cc_w[v], 32'(mcyc[v]));
            chk($sformatf("%s.fpc.s%0d", tag, v), fpc_w[v], mfpc[v]);
            chk($sformatf("%s.faddr.s%0d", tag, v), fa_w[v], mfa[v]);
            chk($sformatf("%s.fdata.s%0d", tag, v), fd_w[v], mfd[v]);
        end
    endtask

    // One clock: drive, check ready, take the edge, update model, compare.
    task automatic cycle(input bit ev, input logic [31:0] ea, input logic [31:0] ed,
                         input bit st, input bit mw, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p, input string tag);
        exp_valid = ev; exp_addr = ea; exp_data = ed; start = st;
        memwrite = mw; dataadr = a; writedata = d; pc = p;
        for (int v = 0; v < 2; v++)
            chk($sformatf("%s.ready.s%0d", tag, v), 32'(rdy_w[v]),
                32'(mst[0] == 0 && la.size() < DEPTH));
        @(posedge clk);
        #1;
        model_edge(ev, ea, ed, st, mw, a, d, p);
        check_all(tag);
        exp_valid = 1'b0; start = 1'b0; memwrite = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
        check_all("clear");
    endtask

    task automatic sched_reset();
        for (int k = 0; k < 20; k++) begin
            s_mw[k] = 1'b0; s_a[k] = '0; s_d[k] = '0; s_pc[k] = '0;
        end
    endtask

    task automatic scenario(input string tag);
        do_clear();
        for (int i = 0; i < n_en; i++)
            cycle(1'b1, en_a[i], en_d[i], merge && (i == n_en - 1), 1'b0, '0, '0, '0, tag);
        if (!(merge && n_en > 0))
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, '0, tag);
        for (int k = 1; k < 19; k++)
            cycle(1'b0, '0, '0, 1'b0, s_mw[k], s_a[k], s_d[k], s_pc[k], tag);
        for (int v = 0; v < 2; v++)
            chk($sformatf("%s.bounded_done.s%0d", tag, v), 32'(done_w[v]), 32'd1);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("in_reset");
        chk("in_reset.ready", 32'(rdy_w[1]), 32'd1);
        reset = 1'b0;

        // Single matching store on the 3rd RUN cycle
        n_en = 1; en_a[0] = 84; en_d[0] = 7; merge = 0; sched_reset();
        s_mw[3] = 1; s_a[3] = 84; s_d[3] = 7; s_pc[3] = 32'h30;
        scenario("t1");
        chk("t1.pass", 32'(pass_w[1]), 32'd1);
        chk("t1.cycles", cc_w[1], 32'd3);
        chk("t1.match", 32'(mc_w[1]), 32'd1);

        // Data mismatch at the expected address
        sched_reset();
        s_mw[1] = 1; s_a[1] = 84; s_d[1] = 6; s_pc[1] = 32'h3C;
        scenario("t2");
        chk("t2.err", 32'(err_w[0]), 32'd1);
        chk("t2.faddr", fa_w[0], 32'd84);
        chk("t2.fdata", fd_w[0], 32'd6);
        chk("t2.fpc", fpc_w[0], 32'h3C);

        // Clear from FAIL, then start on the emptied queue
        do_clear();
        chk("clr.err", 32'(err_w[1]), 32'd0);
        chk("clr.ready", 32'(rdy_w[1]), 32'd1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, '0, "empty");
        chk("empty.err", 32'(err_w[1]), 32'd3);

        // Stray store before the expected one
        sched_reset();
        s_mw[1] = 1; s_a[1] = 80; s_d[1] = 5; s_pc[1] = 32'h10;
        s_mw[2] = 1; s_a[2] = 84; s_d[2] = 7; s_pc[2] = 32'h14;
        scenario("t3");
        chk("t3.lax_pass", 32'(pass_w[0]), 32'd1);
        chk("t3.lax_match", 32'(mc_w[0]), 32'd1);
        chk("t3.strict_faddr", fa_w[1], 32'd80);

        // Timeout with no stores, then a completing store on the last cycle
        sched_reset();
        scenario("t4a");
        chk("t4a.err", 32'(err_w[1]), 32'd2);
        chk("t4a.cycles", cc_w[1], 32'd16);
        s_mw[16] = 1; s_a[16] = 84; s_d[16] = 7;
        scenario("t4b");
        chk("t4b.pass", 32'(pass_w[1]), 32'd1);
        chk("t4b.cycles", cc_w[1], 32'd16);

        // Capacity: five offered, four kept; same-cycle start with the fifth
        n_en = 5; merge = 1; sched_reset();
        for (int i = 0; i < 5; i++) begin
            en_a[i] = 32'(100 + 4 * i); en_d[i] = 32'(i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            s_mw[2 * i + 1] = 1; s_a[2 * i + 1] = en_a[i]; s_d[2 * i + 1] = en_d[i];
        end
        scenario("t5");
        chk("t5.match", 32'(mc_w[1]), 32'd4);
        chk("t5.pass", 32'(pass_w[1]), 32'd1);

        // Asynchronous reset mid-RUN
        do_clear();
        cycle(1'b1, 32'd84, 32'd7, 1'b0, 1'b0, '0, '0, '0, "t6");
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, '0, "t6");
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, "t6");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        chk("t6.async.ready", 32'(rdy_w[0]), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("t6.after");

        // Randomized scenarios
        for (int it = 0; it < 30; it++) begin
            n_en  = int'($urandom_range(0, 5));
            merge = bit'($urandom_range(0, 1));
            for (int i = 0; i < n_en; i++) begin
                en_a[i] = 32'(80 + 4 * $urandom_range(0, 2));
                en_d[i] = 32'($urandom_range(0, 3));
            end
            sched_reset();
            for (int k = 1; k < 19; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    s_mw[k] = 1'b1;
                    s_pc[k] = 32'($urandom);
                    if (n_en > 0 && $urandom_range(0, 1) == 1) begin
                        int j;
                        j = int'($urandom_range(0, n_en - 1));
                        s_a[k] = en_a[j]; s_d[k] = en_d[j];
                    end else begin
                        s_a[k] = 32'(80 + 4 * $urandom_range(0, 2));
                        s_d[k] = 32'($urandom_range(0, 3));
                    end
                end
            end
            scenario($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
